// File: rtl/cu_pkg.sv
// Shared definitions for the instruction-fetch unit: reset defaults,
// the NOP word shown while the buffer is empty, FSM states and the
// layout of one buffered fetch entry.
package cu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          IF_DEPTH_DEF = 2;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam int          ENTRY_W      = 65;

  typedef enum logic [1:0] {
    IF_BOOT  = 2'd0,
    IF_FETCH = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_t;

  // One buffered fetch: {pc, instruction, bus error}
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } if_entry_t;

  // Sequential fetch address; 32-bit arithmetic wraps FFFF_FFFC -> 0
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Redirect targets are word aligned
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Instruction buffer: DEPTH entries of 65 bits, synchronous flush with
// priority over push/pop, push accepted on a full buffer when a pop
// happens in the same cycle.
module if_fifo
  import cu_pkg::*;
#(
  parameter  int DEPTH = IF_DEPTH_DEF,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty,
  output logic [CW-1:0]      count
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               do_pop_s, do_push_s;

  // Pointer advance with wrap for non-power-of-two depths
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + AW'(1);
    end
  endfunction

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_pop_s  = pop && (count_q != '0);
    do_push_s = push && ((count_q != CW'(DEPTH)) || do_pop_s);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Buffer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/cu_if.sv
// Instruction fetch unit: issues credit-limited word fetches, buffers
// in-order responses with their PC, and flushes/restarts on redirect,
// discarding responses to requests issued before the redirect.
module cu_if
  import cu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IF_DEPTH = IF_DEPTH_DEF
) (
  input  logic        soc_clk,
  input  logic        IF_reset_n,
  input  logic        IF_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  input  logic        IDU_ready,
  output logic        Fetch_ready,
  output logic [31:0] Cu_IR,
  output logic [31:0] IF_pc,
  output logic        fetch_err
);

  localparam int            CW      = $clog2(IF_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(IF_DEPTH);

  if_state_t      state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [31:0]    rsp_pc_q, rsp_pc_d;   // PC of the oldest outstanding request
  logic [CW-1:0]  outst_q, outst_d;

  logic [ENTRY_W-1:0] head_s;
  if_entry_t          head_e_s;
  if_entry_t          push_e_s;
  logic               full_s, empty_s;
  logic [CW-1:0]      count_s;
  logic [CW:0]        credit_s;
  logic               mem_req_s, grant_s, rsp_ok_s, push_s, pop_s;

  // Request gating, handshakes and buffer control
  always_comb begin
    credit_s  = {1'b0, outst_q} + {1'b0, count_s};
    mem_req_s = (state_q == IF_FETCH) && (credit_s < DEPTH_W) && !redirect_valid;
    grant_s   = mem_req_s && mem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored
    rsp_ok_s  = mem_rvalid && (outst_q != '0);
    pop_s     = !empty_s && IDU_ready && !IF_stall && !redirect_valid;
    push_s    = rsp_ok_s && (state_q == IF_FETCH) && !redirect_valid
                && (!full_s || pop_s);
    push_e_s.pc    = rsp_pc_q;
    push_e_s.instr = mem_rdata;
    push_e_s.err   = mem_err;
  end

  // FSM next state, fetch/response PCs and outstanding count
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;

    case ({grant_s, rsp_ok_s})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      rsp_pc_d   = word_align(redirect_pc);
      if ((state_q != IF_BOOT) && (outst_q != '0)) begin
        state_d = IF_DRAIN;
      end else begin
        state_d = IF_FETCH;
      end
    end else begin
      case (state_q)
        IF_BOOT: begin
          state_d = IF_FETCH;
        end
        IF_FETCH: begin
          if (grant_s) begin
            fetch_pc_d = pc_next(fetch_pc_q);
          end else begin
            fetch_pc_d = fetch_pc_q;
          end
          if (push_s) begin
            rsp_pc_d = pc_next(rsp_pc_q);
          end else begin
            rsp_pc_d = rsp_pc_q;
          end
        end
        IF_DRAIN: begin
          if (outst_q == '0) begin
            state_d = IF_FETCH;
          end else begin
            state_d = IF_DRAIN;
          end
        end
        default: begin
          state_d = IF_BOOT;
        end
      endcase
    end
  end

  // Control state register
  always_ff @(posedge soc_clk or negedge IF_reset_n) begin
    if (!IF_reset_n) begin
      state_q    <= IF_BOOT;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
    end
  end

  if_fifo #(.DEPTH(IF_DEPTH)) u_fifo (
    .clk   (soc_clk),
    .rst_n (IF_reset_n),
    .flush (redirect_valid),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (push_e_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  assign head_e_s    = if_entry_t'(head_s);
  assign mem_req     = mem_req_s;
  assign mem_addr    = fetch_pc_q;
  assign Fetch_ready = !empty_s;
  assign Cu_IR       = empty_s ? NOP_INSTR : head_e_s.instr;
  assign IF_pc       = empty_s ? 32'h0000_0000 : head_e_s.pc;
  assign fetch_err   = empty_s ? 1'b0 : head_e_s.err;

endmodule

// File: tb/tb_cu_if.sv
// Bench for cu_if: a directed vector table for boot/stall, hand-written
// redirect/wrap/error/reset sequences, then randomized traffic checked
// every cycle against a queue-based model of the fetch unit.
module tb_cu_if;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        soc_clk = 1'b0;
  logic        IF_reset_n = 1'b0;
  logic        IF_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_err = 1'b0;
  logic        IDU_ready = 1'b0;
  logic        Fetch_ready;
  logic [31:0] Cu_IR;
  logic [31:0] IF_pc;
  logic        fetch_err;

  cu_if #(.RESET_PC(32'h0000_0000), .IF_DEPTH(DEPTH)) dut (
    .soc_clk        (soc_clk),
    .IF_reset_n     (IF_reset_n),
    .IF_stall       (IF_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .mem_err        (mem_err),
    .IDU_ready      (IDU_ready),
    .Fetch_ready    (Fetch_ready),
    .Cu_IR          (Cu_IR),
    .IF_pc          (IF_pc),
    .fetch_err      (fetch_err)
  );

  always #5 soc_clk = ~soc_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; bit err; } ent_t;
  req_t        infl[$];   // granted requests awaiting a response, oldest first
  ent_t        mbuf[$];   // instructions waiting for decode
  bit          m_booted;
  bit          m_drain;
  logic [31:0] m_pc;

  typedef struct {
    bit stall, ready, gnt, rv; logic [31:0] rdata; bit err;
    bit req; logic [31:0] addr; bit fr; logic [31:0] pc; logic [31:0] ir; bit ferr;
  } vec_t;
  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    infl.delete();
    mbuf.delete();
    m_pc     = 32'h0000_0000;
    m_booted = 1'b0;
    m_drain  = 1'b0;
  endtask

  function automatic bit model_req();
    return m_booted && !m_drain && ((infl.size() + mbuf.size()) < DEPTH) && !redirect_valid;
  endfunction

  task automatic check_model();
    bit          fr;
    logic [31:0] ir, pc;
    bit          fe;
    fr = (mbuf.size() != 0);
    ir = fr ? mbuf[0].data : NOP;
    pc = fr ? mbuf[0].pc : 32'h0;
    fe = fr ? mbuf[0].err : 1'b0;
    chk("mdl_mem_req", {31'b0, mem_req}, {31'b0, model_req()});
    chk("mdl_mem_addr", mem_addr, m_pc);
    chk("mdl_fetch_ready", {31'b0, Fetch_ready}, {31'b0, fr});
    chk("mdl_cu_ir", Cu_IR, ir);
    chk("mdl_if_pc", IF_pc, pc);
    chk("mdl_fetch_err", {31'b0, fetch_err}, {31'b0, fe});
  endtask

  task automatic model_edge();
    int   n_inf;
    bit   req;
    req_t r;
    ent_t e;
    n_inf = infl.size();
    req   = model_req();
    if (redirect_valid) begin
      mbuf.delete();
      if (mem_rvalid && n_inf > 0) void'(infl.pop_front());
      foreach (infl[i]) infl[i].stale = 1'b1;
      m_drain  = (n_inf != 0);
      m_pc     = redirect_pc & 32'hFFFF_FFFC;
      m_booted = 1'b1;
    end else begin
      if (!m_booted) m_booted = 1'b1;
      else if (m_drain && n_inf == 0) m_drain = 1'b0;
      if (mbuf.size() > 0 && IDU_ready && !IF_stall) void'(mbuf.pop_front());
      if (mem_rvalid && n_inf > 0) begin
        r = infl.pop_front();
        if (!r.stale) begin
          e.pc = r.addr; e.data = mem_rdata; e.err = mem_err;
          mbuf.push_back(e);
        end
      end
      if (req && mem_gnt) begin
        r.addr = m_pc; r.stale = 1'b0;
        infl.push_back(r);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input bit stall, input bit ready, input bit gnt, input bit rv,
                        input logic [31:0] rdata, input bit err,
                        input bit redir, input logic [31:0] rpc);
    IF_stall = stall; IDU_ready = ready; mem_gnt = gnt; mem_rvalid = rv;
    mem_rdata = rdata; mem_err = err; redirect_valid = redir; redirect_pc = rpc;
  endtask

  // Called at a negedge with inputs applied: check, advance model, move to next negedge
  task automatic step();
    #1;
    check_model();
    model_edge();
    @(posedge soc_clk);
    @(negedge soc_clk);
  endtask

  task automatic check_reset_vals();
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0000_0000);
    chk("rst_fetch_ready", {31'b0, Fetch_ready}, 32'h0);
    chk("rst_cu_ir", Cu_IR, NOP);
    chk("rst_if_pc", IF_pc, 32'h0);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'h0);
  endtask

  // Assert reset mid-cycle, check outputs immediately, release at the next negedge
  task automatic do_reset();
    IF_reset_n = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    @(posedge soc_clk);
    @(negedge soc_clk);
    IF_reset_n = 1'b1;
  endtask

  initial begin
    // stall ready gnt rv rdata err | req addr fr pc ir ferr
    vt[0]  = '{0,1,1,0,32'h0,0,          0,32'h0,0,32'h0,NOP,0};
    vt[1]  = '{0,1,1,0,32'h0,0,          1,32'h0,0,32'h0,NOP,0};
    vt[2]  = '{0,1,1,1,32'h1111_0001,0,  1,32'h4,0,32'h0,NOP,0};
    vt[3]  = '{1,1,1,1,32'h2222_0002,0,  0,32'h8,1,32'h0,32'h1111_0001,0};
    vt[4]  = '{1,1,1,0,32'h0,0,          0,32'h8,1,32'h0,32'h1111_0001,0};
    vt[5]  = '{1,1,1,0,32'h0,0,          0,32'h8,1,32'h0,32'h1111_0001,0};
    vt[6]  = '{1,1,1,0,32'h0,0,          0,32'h8,1,32'h0,32'h1111_0001,0};
    vt[7]  = '{1,1,1,0,32'h0,0,          0,32'h8,1,32'h0,32'h1111_0001,0};
    vt[8]  = '{1,1,1,0,32'h0,0,          0,32'h8,1,32'h0,32'h1111_0001,0};
    vt[9]  = '{0,1,0,0,32'h0,0,          0,32'h8,1,32'h0,32'h1111_0001,0};
    vt[10] = '{0,0,0,0,32'h0,0,          1,32'h8,1,32'h4,32'h2222_0002,0};
    vt[11] = '{0,1,0,0,32'h0,0,          1,32'h8,1,32'h4,32'h2222_0002,0};
    vt[12] = '{0,0,0,0,32'h0,0,          1,32'h8,0,32'h0,NOP,0};

    model_reset();
    repeat (2) @(negedge soc_clk);
    #1;
    check_reset_vals();
    @(negedge soc_clk);
    IF_reset_n = 1'b1;

    // Boot, first fetches, stall until credits are used up, then drain the buffer
    for (int i = 0; i < 13; i++) begin
      set_in(vt[i].stall, vt[i].ready, vt[i].gnt, vt[i].rv, vt[i].rdata, vt[i].err, 1'b0, 32'h0);
      #1;
      chk("tbl_mem_req", {31'b0, mem_req}, {31'b0, vt[i].req});
      chk("tbl_mem_addr", mem_addr, vt[i].addr);
      chk("tbl_fetch_ready", {31'b0, Fetch_ready}, {31'b0, vt[i].fr});
      chk("tbl_if_pc", IF_pc, vt[i].pc);
      chk("tbl_cu_ir", Cu_IR, vt[i].ir);
      chk("tbl_fetch_err", {31'b0, fetch_err}, {31'b0, vt[i].ferr});
      step();
    end

    // Redirect with two requests outstanding; both responses are dropped
    set_in(0,1,1,0,32'h0,0,0,32'h0); step();
    set_in(0,1,1,0,32'h0,0,0,32'h0); step();
    set_in(0,1,1,0,32'h0,0,1,32'h0000_0103); #1;
    chk("redir_no_req", {31'b0, mem_req}, 32'h0);
    step();
    set_in(0,1,0,1,32'hDEAD_0001,0,0,32'h0); step();
    set_in(0,1,0,1,32'hDEAD_0002,0,0,32'h0); step();
    set_in(0,1,0,0,32'h0,0,0,32'h0); #1;
    chk("drop_fetch_ready", {31'b0, Fetch_ready}, 32'h0);
    chk("drain_no_req", {31'b0, mem_req}, 32'h0);
    step();
    set_in(0,1,0,0,32'h0,0,0,32'h0); #1;
    chk("redir_req", {31'b0, mem_req}, 32'h1);
    chk("redir_addr", mem_addr, 32'h0000_0100);
    step();

    // Address wrap at the top of the space, then a bus error on one entry
    set_in(0,1,0,0,32'h0,0,1,32'hFFFF_FFFF); step();
    set_in(0,1,1,0,32'h0,0,0,32'h0); #1;
    chk("top_addr", mem_addr, 32'hFFFF_FFFC);
    step();
    set_in(0,1,0,0,32'h0,0,0,32'h0); #1;
    chk("wrap_addr", mem_addr, 32'h0000_0000);
    step();
    set_in(0,0,1,1,32'hBAD0_0000,1,0,32'h0); step();
    set_in(0,0,0,1,32'h600D_0000,0,0,32'h0); #1;
    chk("err_if_pc", IF_pc, 32'hFFFF_FFFC);
    chk("err_flag", {31'b0, fetch_err}, 32'h1);
    chk("err_cu_ir", Cu_IR, 32'hBAD0_0000);
    step();
    set_in(0,1,0,0,32'h0,0,0,32'h0); #1;
    chk("err_flag_hold", {31'b0, fetch_err}, 32'h1);
    step();
    set_in(0,1,0,0,32'h0,0,0,32'h0); #1;
    chk("next_if_pc", IF_pc, 32'h0000_0000);
    chk("next_no_err", {31'b0, fetch_err}, 32'h0);
    chk("next_cu_ir", Cu_IR, 32'h600D_0000);
    step();
    set_in(0,1,0,0,32'h0,0,0,32'h0); step();

    // Reset in the middle of a drain; stale responses afterwards are ignored
    set_in(0,1,1,0,32'h0,0,0,32'h0); step();
    set_in(0,1,1,0,32'h0,0,0,32'h0); step();
    set_in(0,1,0,0,32'h0,0,1,32'h0000_0200); step();
    set_in(0,1,0,0,32'h0,0,0,32'h0);
    #2;
    do_reset();
    set_in(0,1,0,1,32'h5555_0001,0,0,32'h0); step();
    set_in(0,1,0,1,32'h5555_0002,0,0,32'h0); step();
    set_in(0,1,0,0,32'h0,0,0,32'h0); #1;
    chk("post_rst_fetch_ready", {31'b0, Fetch_ready}, 32'h0);
    chk("post_rst_addr", mem_addr, 32'h0000_0000);
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      bit          st, rd, gn, rv, er, rdr;
      logic [31:0] rpc, dat;
      if ($urandom_range(0, 399) == 0) begin
        #2;
        do_reset();
        continue;
      end
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 9) < 7);
      gn  = ($urandom_range(0, 9) < 6);
      rv  = (infl.size() > 0) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 29) == 0);
      er  = ($urandom_range(0, 9) == 0);
      rdr = ($urandom_range(0, 29) == 0);
      dat = $urandom;
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = rpc | 32'hFFFF_FFF0;
      set_in(st, rd, gn, rv, dat, er, rdr, rpc);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
